// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer
//   Captures architectural commit events from the single-cycle mips core
//   (register-file writes and data-memory word writes) into a circular FIFO
//   and hands them out one per valid/ready handshake, in commit order.
//
// Ports
//   clk, reset              single clock, synchronous active-high reset
//   grf_we/pc/addr/wdata    GRF write commit (writes to $0 are ignored)
//   dm_we/pc/addr/wdata     DM word write commit
//   trc_valid/ready         output handshake; trc_kind 0 = GRF, 1 = DM
//   trc_pc/addr/data        head entry fields (don't-care while !trc_valid)
//   level                   occupancy, 0..DEPTH
//   overflow, conflict      sticky error flags, cleared only by reset
//   drop_cnt                saturating count of events lost to a full FIFO
module commit_trace_buffer #(
   parameter int DEPTH  = 16,
   parameter int DROP_W = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     grf_we,
   input  logic [31:0]              grf_pc,
   input  logic [4:0]               grf_addr,
   input  logic [31:0]              grf_wdata,
   input  logic                     dm_we,
   input  logic [31:0]              dm_pc,
   input  logic [31:0]              dm_addr,
   input  logic [31:0]              dm_wdata,
   output logic                     trc_valid,
   input  logic                     trc_ready,
   output logic                     trc_kind,
   output logic [31:0]              trc_pc,
   output logic [31:0]              trc_addr,
   output logic [31:0]              trc_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic                     conflict,
   output logic [DROP_W-1:0]        drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef struct packed {
      logic        kind;
      logic [31:0] pc;
      logic [31:0] addr;
      logic [31:0] data;
   } trc_entry_t;

   trc_entry_t          mem [DEPTH];
   logic [AW-1:0]       wr_ptr, rd_ptr;
   trc_entry_t          ev;
   logic                ev_vld, deq, full, enq, drop;

   // Event selection: GRF wins over DM when both fire; a $0 write never
   // enqueues and never lets the DM event through in its place.
   always_comb begin
      ev     = '0;
      ev_vld = 1'b0;
      if (grf_we) begin
         ev_vld = (grf_addr != 5'd0);
         ev     = '{kind: 1'b0, pc: grf_pc, addr: {27'b0, grf_addr}, data: grf_wdata};
      end else if (dm_we) begin
         ev_vld = 1'b1;
         ev     = '{kind: 1'b1, pc: dm_pc, addr: dm_addr, data: dm_wdata};
      end
   end

   assign trc_valid = (level != '0);
   assign full      = (level == LW'(DEPTH));
   assign deq       = trc_valid && trc_ready;
   // A dequeue on the same edge frees the slot, so a full FIFO still accepts.
   assign enq       = ev_vld && (!full || deq);
   assign drop      = ev_vld && full && !deq;

   assign trc_kind  = mem[rd_ptr].kind;
   assign trc_pc    = mem[rd_ptr].pc;
   assign trc_addr  = mem[rd_ptr].addr;
   assign trc_data  = mem[rd_ptr].data;

   // Storage is intentionally not reset; validity is tracked by level.
   always_ff @(posedge clk) begin
      if (!reset && enq)
         mem[wr_ptr] <= ev;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
         conflict <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (enq) wr_ptr <= wr_ptr + AW'(1);
         if (deq) rd_ptr <= rd_ptr + AW'(1);
         if (enq && !deq)      level <= level + LW'(1);
         else if (deq && !enq) level <= level - LW'(1);
         if (grf_we && dm_we) conflict <= 1'b1;
         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_commit_trace_buffer.sv
module tb_commit_trace_buffer;

   localparam int DEPTH  = 16;
   localparam int DROP_W = 4;
   localparam int MAXD   = (1 << DROP_W) - 1;

   logic clk = 1'b0, reset = 1'b1;
   logic grf_we = 0, dm_we = 0, trc_ready = 0;
   logic [31:0] grf_pc = 0, grf_wdata = 0, dm_pc = 0, dm_addr = 0, dm_wdata = 0;
   logic [4:0]  grf_addr = 0;
   logic trc_valid, trc_kind, overflow, conflict;
   logic [31:0] trc_pc, trc_addr, trc_data;
   logic [$clog2(DEPTH):0] level;
   logic [DROP_W-1:0] drop_cnt;

   commit_trace_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
      .clk(clk), .reset(reset),
      .grf_we(grf_we), .grf_pc(grf_pc), .grf_addr(grf_addr), .grf_wdata(grf_wdata),
      .dm_we(dm_we), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_kind(trc_kind),
      .trc_pc(trc_pc), .trc_addr(trc_addr), .trc_data(trc_data),
      .level(level), .overflow(overflow), .conflict(conflict), .drop_cnt(drop_cnt));

   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: an ordered queue of committed events plus flags.
   typedef struct { bit kind; bit [31:0] pc, addr, data; } ent_t;
   ent_t q[$];
   ent_t e;
   bit   m_over, m_conf, has_ev, deq, started;
   int   m_drop;

   always @(posedge clk) begin
      if (reset) begin
         q.delete();
         m_over = 0; m_conf = 0; m_drop = 0;
      end else begin
         deq    = (q.size() != 0) && trc_ready;
         has_ev = 0;
         if (grf_we && dm_we) m_conf = 1;
         if (grf_we) begin
            if (grf_addr != 0) begin
               has_ev = 1;
               e = '{0, grf_pc, {27'b0, grf_addr}, grf_wdata};
            end
         end else if (dm_we) begin
            has_ev = 1;
            e = '{1, dm_pc, dm_addr, dm_wdata};
         end
         if (deq) void'(q.pop_front());
         if (has_ev) begin
            if (q.size() < DEPTH) q.push_back(e);
            else begin
               m_over = 1;
               if (m_drop < MAXD) m_drop++;
            end
         end
      end
      started = 1;
   end

   always @(negedge clk) if (started) begin
      chk("valid", trc_valid, q.size() != 0);
      chk("level", level, q.size());
      chk("overflow", overflow, m_over);
      chk("conflict", conflict, m_conf);
      chk("drop_cnt", drop_cnt, m_drop);
      if (q.size() != 0)
         chk("head", {trc_kind, trc_pc, trc_addr, trc_data},
             {q[0].kind, q[0].pc, q[0].addr, q[0].data});
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic idle();
      grf_we = 0; dm_we = 0;
   endtask

   task automatic grf(logic [31:0] pc, logic [4:0] a, logic [31:0] d);
      grf_we = 1; grf_pc = pc; grf_addr = a; grf_wdata = d; dm_we = 0;
   endtask

   task automatic dm(logic [31:0] pc, logic [31:0] a, logic [31:0] d);
      dm_we = 1; dm_pc = pc; dm_addr = a; dm_wdata = d; grf_we = 0;
   endtask

   task automatic do_reset();
      reset = 1; idle(); step(); reset = 0;
   endtask

   initial begin
      do_reset();
      chk("rst_valid", trc_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_flags", {overflow, conflict, drop_cnt}, 0);

      // Basic order
      trc_ready = 1;
      grf(32'h3000, 5'd3, 32'h1234_5678); step();
      chk("bo_valid1", trc_valid, 1);
      chk("bo_e1", {trc_kind, trc_pc, trc_addr, trc_data}, {1'b0, 32'h3000, 32'h3, 32'h1234_5678});
      dm(32'h3004, 32'h4, 32'hDEAD_BEEF); step();
      chk("bo_valid2", trc_valid, 1);
      chk("bo_e2", {trc_kind, trc_pc, trc_addr, trc_data}, {1'b1, 32'h3004, 32'h4, 32'hDEAD_BEEF});
      idle(); step();
      chk("bo_empty", trc_valid, 0);

      // $0 filter and conflict
      trc_ready = 0;
      grf(32'h3008, 5'd0, 32'h1111); step();
      chk("z_level", level, 0);
      grf(32'h300C, 5'd5, 32'h5555); dm_we = 1; dm_addr = 32'h40; step();
      idle();
      chk("cf_level", level, 1);
      chk("cf_entry", {trc_kind, trc_addr, trc_data}, {1'b0, 32'h5, 32'h5555});
      chk("cf_flags", {conflict, drop_cnt}, {1'b1, 4'd0});
      trc_ready = 1; step();
      chk("cf_drained", level, 0);

      // Full and overflow, then full with simultaneous enqueue/dequeue
      do_reset();
      trc_ready = 0;
      for (int i = 0; i < 18; i++) begin
         grf(32'h3000 + 4 * i, 5'((i % 31) + 1), i); step();
      end
      idle();
      chk("full_level", level, 16);
      chk("full_over", overflow, 1);
      chk("full_drop", drop_cnt, 2);
      trc_ready = 1; grf(32'h4000, 5'd9, 32'hAAAA); step();
      idle();
      chk("simul_level", level, 16);
      chk("simul_drop", drop_cnt, 2);
      for (int k = 0; k < 16; k++) begin
         chk("drain_data", trc_data, (k < 15) ? 32'(k + 1) : 32'hAAAA);
         step();
      end
      chk("drain_empty", trc_valid, 0);

      // Backpressure: 40 random events under random ready
      do_reset();
      for (int n = 0; n < 40; ) begin
         trc_ready = 1'($urandom_range(0, 1));
         idle();
         if ($urandom_range(0, 3) != 0) begin
            if ($urandom_range(0, 1) != 0)
               grf($urandom, 5'($urandom_range(1, 31)), $urandom);
            else
               dm($urandom, {$urandom_range(0, 1023), 2'b00}, $urandom);
            n++;
         end
         step();
      end
      idle(); trc_ready = 1;
      for (int k = 0; k < DEPTH + 2; k++) step();
      chk("bp_empty", trc_valid, 0);

      // Random mix incl. $0 writes, conflicts, overflow and saturation
      for (int k = 0; k < 300; k++) begin
         trc_ready = ($urandom_range(0, 3) == 0);
         grf_we = 1'($urandom_range(0, 1)); grf_addr = 5'($urandom_range(0, 7));
         grf_pc = $urandom; grf_wdata = $urandom;
         dm_we = ($urandom_range(0, 3) == 0); dm_pc = $urandom; dm_addr = $urandom; dm_wdata = $urandom;
         step();
      end
      idle();
      chk("rnd_sat", drop_cnt, MAXD);

      // Reset mid-operation with level 7 and overflow set
      do_reset();
      trc_ready = 0;
      for (int i = 0; i < 17; i++) begin
         dm(32'h5000 + 4 * i, 32'(4 * i), i); step();
      end
      idle(); trc_ready = 1;
      for (int i = 0; i < 9; i++) step();
      trc_ready = 0;
      chk("pre_rst", {level, overflow}, {5'd7, 1'b1});
      reset = 1; grf(32'h6000, 5'd7, 32'h7777); step();
      reset = 0; idle();
      chk("mr_valid", trc_valid, 0);
      chk("mr_level", level, 0);
      chk("mr_flags", {overflow, conflict, drop_cnt}, 0);
      step();
      chk("mr_nocap", level, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Receive-side companion to the single-cycle `mips` core in the P4 test environment. The testbench only drives `clk` and `reset` into the core; this block captures the core's architectural commit events instead:
- register-file writes (GRF);
- data-memory writes (DM).

It queues them in a FIFO and presents them one per handshake to a downstream checker or printer. A commit trace can then be compared cycle-independently against a reference simulator.

## Interface
Parameters:
- `DEPTH`, 16, FIFO entries; power of two, ≥ 2.
- `DROP_W`, 16, width of the dropped-event counter.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `grf_we`  in  1  core commits a GRF write this cycle.
- `grf_pc`  in  32  PC of the committing instruction.
- `grf_addr`  in  5  destination register.
- `grf_wdata`  in  32  value written.
- `dm_we`  in  1  core commits a DM word write this cycle.
- `dm_pc`  in  32  PC of the store.
- `dm_addr`  in  32  byte address, word-aligned.
- `dm_wdata`  in  32  value stored.
- `trc_valid`  out  1  head entry is available.
- `trc_ready`  in  1  consumer accepts the head entry.
- `trc_kind`  out  1  entry type: 0 = GRF, 1 = DM.
- `trc_pc`  out  32  PC of the entry.
- `trc_addr`  out  32  `{27'b0, grf_addr}` for GRF entries, `dm_addr` for DM entries.
- `trc_data`  out  32  data of the entry.
- `level`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky: at least one event was dropped because the FIFO was full.
- `conflict`  out  1  sticky: `grf_we` and `dm_we` were sampled high in the same cycle.
- `drop_cnt`  out  DROP_W  number of dropped events; saturates at all-ones.

## Operation
- Event capture: at each rising edge with `reset` low, the inputs are sampled. At most one event is enqueued per cycle.
  - `grf_we` high with `grf_addr != 0` → GRF entry.
  - `grf_we` high with `grf_addr == 0` → ignored. Not an error and not counted as a drop.
  - `dm_we` high → DM entry.
  - Both high → the GRF entry is enqueued (subject to the `$0` rule) and `conflict` is set. The DM event is lost, but it is not counted in `drop_cnt`.
- FIFO storage:
  - Circular buffer with `wr_ptr` and `rd_ptr`, each `$clog2(DEPTH)` bits, wrapping from `DEPTH-1` to 0.
  - `level` is held as a separate counter from 0 to `DEPTH`.
  - Full when `level == DEPTH`; empty when `level == 0`.
- Dequeue: occurs when `trc_valid && trc_ready` at the edge. `rd_ptr` advances and `level` decrements, unless an enqueue happens on the same edge.
- Simultaneous enqueue and dequeue:
  - `level` is unchanged and both pointers advance.
  - This is legal even when full: the freed slot absorbs the new entry, and no drop occurs.
- Full with no dequeue, and an event arrives:
  - The event is discarded.
  - `overflow` ← 1.
  - `drop_cnt` ← `drop_cnt + 1`, saturating.
- Output fields:
  - `trc_kind`, `trc_pc`, `trc_addr` and `trc_data` are read from the head slot.
  - While `trc_valid && !trc_ready` they stay stable.
  - When `trc_valid` is 0 their values are don't-care.
- `trc_valid = (level != 0)`.
- Sticky flags `overflow` and `conflict` clear only on `reset`.

## Timing
- Reset:
  - `reset` high at an edge clears `wr_ptr`, `rd_ptr`, `level`, `overflow`, `conflict` and `drop_cnt` to 0. Hence `trc_valid` = 0.
  - Entries in flight are discarded, even in mid-handshake.
  - Events presented in a reset cycle are ignored.
  - Storage contents are not reset.
- Latency: an event sampled at edge N appears with `trc_valid` = 1 after edge N. There is no same-cycle bypass from input to output.
- Throughput: one enqueue and one dequeue per cycle, sustained.
- `level` and all flags are registered. They reflect the state after the most recent edge.
- Ordering: entries are output in strict commit order. There is no reordering between GRF and DM entries.

## Test plan
- Basic order:
  - Stimulus (`trc_ready` = 1): GRF `$3` ← 0x12345678 at pc 0x3000, next cycle DM [0x0004] ← 0xDEADBEEF at pc 0x3004.
  - Required response: two consecutive handshakes. First {0, 0x3000, 0x3, 0x12345678}, then {1, 0x3004, 0x4, 0xDEADBEEF}. `trc_valid` rises exactly one cycle after each event.
- `$0` filter and conflict:
  - Stimulus: `grf_we` with `grf_addr` = 0, then a cycle with `grf_we` = `dm_we` = 1 and `grf_addr` = 5.
  - Required response: only the `$5` entry is emitted; `conflict` = 1; `drop_cnt` = 0.
- Full and overflow (`DEPTH` = 16, `trc_ready` = 0):
  - Stimulus: 18 GRF events.
  - Required response: `level` = 16, `overflow` = 1, `drop_cnt` = 2. Draining yields exactly the first 16 events in order, with pointers wrapping correctly.
- Full with simultaneous enqueue and dequeue:
  - Stimulus: with `level` = 16, raise `trc_ready` and present an event in the same cycle.
  - Required response: `level` stays 16; `drop_cnt` is unchanged; the new event emerges 16th in line.
- Backpressure stability:
  - Stimulus: toggle `trc_ready` pseudo-randomly across 40 events.
  - Required response: outputs stay stable while stalled; every event is emitted exactly once, in order.
- Reset mid-operation:
  - Stimulus: with `level` = 7 and `overflow` = 1, assert `reset` for one cycle while also presenting an event.
  - Required response: next cycle `trc_valid` = 0, `level` = 0, all flags 0. The event is not captured.
